// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 codes, FSM state encoding and byte-enable constants
//            for the LSU memory stage.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_R = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational store lane steering, load extract/extend and
//            misaligned / reserved-funct3 fault detection.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  hold_f3_i,
  input  logic [1:0]  hold_off_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  output logic [31:0] rdata_o
);

  logic       w_reserved;
  logic       w_misaligned;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (funct3_i[1:0])
      2'b01:   w_misaligned = addr_lo_i[0];
      2'b10:   w_misaligned = |addr_lo_i;
      default: w_misaligned = 1'b0;
    endcase
    if (is_store_i) w_reserved = !(funct3_i inside {F3_LB, F3_LH, F3_LW});
    else            w_reserved = !(funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    fault_o = w_reserved | w_misaligned;
  end

  // Loads reuse the same lane pattern so the bus sees the bytes being read.
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = BE_BYTE << addr_lo_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o = {2{rs2_i[15:0]}};
      end
      default: begin
        be_o    = BE_WORD;
        wdata_o = rs2_i;
      end
    endcase
  end

  always_comb begin
    case (hold_off_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
    w_half = hold_off_i[1] ? word_i[31:16] : word_i[15:0];
    case (hold_f3_i)
      F3_LB:   rdata_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  rdata_o = {24'd0, w_byte};
      F3_LH:   rdata_o = {{16{w_half[15]}}, w_half};
      F3_LHU:  rdata_o = {16'd0, w_half};
      default: rdata_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : M-stage load/store controller with req/gnt/rvalid data bus.
//            Optional wait timeout compiled in with LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        Stall_M,
  output logic        FaultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] data_q, data_d;

  logic        w_access;
  logic        w_fault;
  logic        w_legal;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  assign w_access = MemReadM | MemWriteM;
  assign w_legal  = w_access & ~w_fault;

  lsu_align u_align (
    .funct3_i   (Funct3M),
    .is_store_i (MemWriteM),
    .addr_lo_i  (ALUResultM[1:0]),
    .rs2_i      (WriteDataM),
    .hold_f3_i  (f3_q),
    .hold_off_i (off_q),
    .word_i     (data_q),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .fault_o    (w_fault),
    .rdata_o    (w_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (!w_timeout) begin
      if (state_q == S_IDLE && w_legal && !dmem_gnt)      cnt_d = cnt_q + 1'b1;
      else if (state_q == S_WAIT_R && !dmem_rvalid)       cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    data_d     = data_q;
    ReadDataM  = '0;
    Stall_M    = 1'b0;
    FaultM     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (w_access && (w_fault || w_timeout)) begin
          FaultM = 1'b1;
        end else if (w_legal) begin
          dmem_req   = 1'b1;
          dmem_we    = MemWriteM;
          dmem_addr  = {ALUResultM[31:2], 2'b00};
          dmem_be    = w_be;
          dmem_wdata = MemWriteM ? w_wdata : '0;
          if (!dmem_gnt) begin
            Stall_M = 1'b1;
          end else if (!MemWriteM) begin
            Stall_M = 1'b1;
            f3_d    = Funct3M;
            off_d   = ALUResultM[1:0];
            state_d = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (w_timeout) begin
          FaultM  = 1'b1;
          state_d = S_IDLE;
        end else begin
          Stall_M = 1'b1;
          if (dmem_rvalid) begin
            data_d  = dmem_rdata;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        ReadDataM = w_rdata;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs stay quiet for the whole time reset is held, whatever the inputs.
    if (!reset) begin
      ReadDataM  = '0;
      Stall_M    = 1'b0;
      FaultM     = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = '0;
      dmem_wdata = '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage controller between the execute/memory pipeline register outputs and the external data-memory bus.
- Consumes ALUResultM, WriteDataM and the load/store controls of the instruction in M.
- Issues byte-lane-steered bus requests with a req/gnt/rvalid handshake.
- Returns sign/zero-extended ReadDataM to the memory/writeback register, and raises Stall_M to the hazard unit while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waited for gnt or rvalid. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- MemReadM  input  1  load in M stage
- MemWriteM  input  1  store in M stage
- Funct3M  input  3  RV32I load/store funct3
- ALUResultM  input  32  effective byte address
- WriteDataM  input  32  store data (rs2)
- ReadDataM  output  32  extended load data, valid in the cycle Stall_M is low
- Stall_M  output  1  freeze F/D/E/M; hazard unit bubbles W
- FaultM  output  1  one-cycle pulse: misaligned access, reserved funct3, or timeout
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_gnt  input  1  request accepted this cycle
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  32  read data word

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - Data/funct3/offset holding registers are cleared.
  - ReadDataM=0, Stall_M=0, FaultM=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
- Access decode:
  - access = MemReadM|MemWriteM.
  - MemWriteM has priority if both are asserted.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Legal load funct3: 000/001/010/100/101. Legal store funct3: 000/001/010. Any other funct3 is reserved.
- State IDLE:
  - No access: req=0, Stall_M=0.
  - Access with fault: req=0, Stall_M=0, FaultM=1 for this cycle, ReadDataM=0. The instruction retires without a bus transaction.
  - Legal access: req=1 combinationally; we, addr, be and wdata are driven from the inputs.
    - gnt=0: Stall_M=1, remain in IDLE.
    - gnt=1 on a store: Stall_M=0, store complete, stay in IDLE.
    - gnt=1 on a load: Stall_M=1, capture Funct3M and addr[1:0], go to WAIT_R.
- State WAIT_R: req=0, Stall_M=1. On rvalid, capture dmem_rdata and go to RESP.
- State RESP: Stall_M=0. ReadDataM = extract(held word, held offset, held funct3). Next state is IDLE.
- Load latency: min 3 cycles in M (gnt in cycle 0, rvalid in cycle 1, RESP in cycle 2). Store latency: 1 cycle with immediate gnt.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Load extract:
  - LB/LBU: byte at offset, sign- or zero-extended.
  - LH/LHU: half at offset[1], sign- or zero-extended.
  - LW: full word.
- ReadDataM is 0 in every state except RESP.
- rvalid seen in IDLE or RESP (stale, e.g. after reset): ignored.
- gnt without req: ignored.
- Reset asserted in WAIT_R: the access is abandoned, and any later rvalid is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - 8-bit-minimum wait counter, sized by $clog2(TIMEOUT_CYCLES+1).
  - Counts cycles in IDLE-waiting-gnt and in WAIT_R; cleared on gnt, on rvalid, and in any other state.
  - When the count reaches TIMEOUT_CYCLES: FaultM pulses, Stall_M drops, req deasserts, ReadDataM=0, state returns to IDLE.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - State encoding IDLE/WAIT_R/RESP.
  - Byte-enable constants.
- Sub-module lsu_align (combinational): store lane steering, load extract/extend, and fault detect. It is instantiated once in the top-level.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt same cycle -> req=1, we=1, be=1111, wdata=0xDEADBEEF, Stall_M=0 in that cycle.
- SB addr=0x103, rs2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB addr=0x102, rdata=0x12F03456, gnt at cycle 0, rvalid at cycle 1 -> Stall_M high for cycles 0-1; cycle 2 ReadDataM=0xFFFFFFF0, Stall_M=0. The same access as LBU gives 0x000000F0.
- LH addr=0x101 -> no req, FaultM=1 for one cycle, Stall_M=0, ReadDataM=0. Reserved Funct3M=011 gives the same response.
- gnt withheld 5 cycles, then LW with rvalid 3 cycles after gnt -> Stall_M held continuously until RESP; ReadDataM=rdata in the RESP cycle only.
- Reset pulled low in WAIT_R, then rvalid arrives after release -> state IDLE, all outputs 0, rvalid ignored. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no rvalid -> FaultM pulse after 4 cycles in WAIT_R, return to IDLE.
